node_packetizer: RTL and testbench
==================================

Name: node_packetizer

Overview:
Network-interface transmitter for the local port of a mesh node. Takes a packet descriptor (destination, head payload, body length) plus a stream of body words, and emits a well-formed sequence of noc_params::flit_t flits (HEAD/BODY/TAIL or a single HEADTAIL) into the router's local input port. Uses per-VC credit flow control and round-robin VC selection.

Parameters:
BUFFER_SIZE, 8, router input buffer depth per VC; initial credit count per VC.
MAX_BODY_FLITS, 15, maximum body+tail flits per packet; LEN_W = $clog2(MAX_BODY_FLITS+1).
(VC_NUM, VC_SIZE, FLIT_DATA_SIZE, DEST_ADDR_SIZE_X/Y, HEAD_PAYLOAD_SIZE come from noc_params. Defaults: 2, 1, 22, 3/3, 16.)

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  asynchronous, active-low reset.
pkt_valid_i  in  1  packet descriptor valid.
pkt_ready_o  out  1  descriptor accepted when valid&ready.
pkt_x_dest_i  in  DEST_ADDR_SIZE_X  destination x.
pkt_y_dest_i  in  DEST_ADDR_SIZE_Y  destination y.
pkt_head_pl_i  in  HEAD_PAYLOAD_SIZE  head payload.
pkt_body_len_i  in  LEN_W  number of flits after head (0 = HEADTAIL packet).
body_valid_i  in  1  body word valid.
body_ready_o  out  1  body word consumed when valid&ready.
body_data_i  in  FLIT_DATA_SIZE  body/tail payload (bt_pl).
vc_allocatable_i  in  VC_NUM  router reports the VC is free for a new packet.
credit_i  in  VC_NUM  one-cycle pulse per freed buffer slot, per VC.
flit_o  out  $bits(flit_t)  registered outgoing flit.
valid_flit_o  out  1  flit_o valid this cycle.

Behaviour:
- Reset (rst=0, async): state=IDLE; valid_flit_o=0; flit_o=0; pkt_ready_o=0; body_ready_o=0; every credit counter=BUFFER_SIZE; RR pointer=VC_NUM-1. A partially sent packet is dropped and nothing further of it is sent.
- Credit counters ($clog2(BUFFER_SIZE+1) bits per VC): decrement when a flit is launched on that VC; increment on credit_i[v]; both in the same cycle -> unchanged. Increment at BUFFER_SIZE is an error: the counter saturates and a simulation assertion fires.
- Eligible VC: vc_allocatable_i[v]=1 and credit[v]>0.
- FSM states IDLE, HEAD, BODY.
  IDLE: pkt_ready_o = any eligible VC (combinational). On handshake, latch dest, payload and len. Pick the first eligible VC after the RR pointer, wrapping; latch it into cur_vc and update the pointer. Go to HEAD.
  HEAD: if credit[cur_vc]>0, the next edge registers flit_o = {label, cur_vc, head_data}, with label=HEADTAIL if len==0, else HEAD. Also valid_flit_o<=1 and the credit decrements. Then go to IDLE if len==0, else BODY with remaining=len. If there is no credit, stay in HEAD with valid_flit_o=0.
  BODY: body_ready_o = (credit[cur_vc]>0). On body handshake, the next edge registers flit_o = {label, cur_vc, body_data_i}, with label=TAIL if remaining==1, else BODY. valid_flit_o<=1, remaining decrements and the credit decrements. After TAIL go to IDLE.
- valid_flit_o is 0 in any cycle where no flit was launched on the previous edge. flit_o holds its last value when not valid.
- Latency: descriptor handshake at edge N -> head on flit_o after edge N+1, given credit. Each body handshake appears on flit_o one cycle later. Throughput is 1 flit/cycle with credit. Minimum packet gap is 1 cycle (IDLE).
- pkt_body_len_i > MAX_BODY_FLITS cannot occur by width when MAX_BODY_FLITS=2^k-1. Otherwise it is a simulation assertion.
- vc_allocatable_i is sampled only in IDLE. Deassertion mid-packet is ignored.

Optional Feature:
Macro PACKETIZER_STATS_EN.
- Defined: adds outputs pkt_count_o[15:0] and flit_count_o[15:0].
  - Both reset to 0.
  - pkt_count_o increments on each TAIL/HEADTAIL launch.
  - flit_count_o increments on each flit launch.
  - Both wrap at 16'hFFFF -> 0.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- HEADTAIL: after reset, both VCs allocatable; descriptor x=3 y=1 pl=16'hBEEF len=0 -> one flit: label HEADTAIL, vc 0, x_dest 3, y_dest 1, head_pl BEEF. credit[0]=7. Back to IDLE.
- 4-flit packet: len=3, bodies 22'h1, 22'h2, 22'h3 streamed back-to-back -> HEAD, BODY(1), BODY(2), TAIL(3) on 4 consecutive cycles, all vc 0. credit[0]=4.
- Credit stall: BUFFER_SIZE=8, no credit_i returns, len=15 -> 8 flits launched, then body_ready_o=0. One credit_i[vc] pulse -> exactly one more flit.
- Round robin: two consecutive 1-flit packets with both VCs allocatable -> first on vc 0, second on vc 1. With vc_allocatable_i=2'b01, the second also goes on vc 0.
- Simultaneous credit+launch: credit_i pulses in the same cycle a flit launches on that VC -> counter unchanged. With no VC eligible (vc_allocatable_i=0), pkt_ready_o=0.
- Reset mid-packet: rst low after HEAD of a len=5 packet -> valid_flit_o=0, credits=8, state IDLE. No BODY/TAIL is ever emitted for that packet.

Source files
------------

// File: rtl/node_packetizer.sv
// node_packetizer -- local-port NoC transmitter.
//
// Turns a packet descriptor (dest x/y, head payload, body length) plus a
// stream of body words into HEAD/BODY/TAIL (or a single HEADTAIL) flits for
// the router's local input port. One VC is chosen per packet by round robin
// among VCs that are allocatable and have credit. Per-VC credits gate every
// flit launch.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   pkt_*_i / pkt_ready_o   descriptor valid/ready handshake and fields
//   body_*_i / body_ready_o body word valid/ready handshake and payload
//   vc_allocatable_i     per-VC "free for a new packet" from the router
//   credit_i             per-VC one-cycle credit return pulse
//   flit_o, valid_flit_o registered outgoing flit and its valid
//
// Optional build macro PACKETIZER_STATS_EN adds pkt_count_o / flit_count_o
// (16-bit wrapping counters of packets and flits launched).

package noc_params;
  localparam int VC_NUM            = 2;
  localparam int VC_SIZE           = 1;
  localparam int FLIT_DATA_SIZE    = 22;
  localparam int DEST_ADDR_SIZE_X  = 3;
  localparam int DEST_ADDR_SIZE_Y  = 3;
  localparam int HEAD_PAYLOAD_SIZE = 16;

  typedef enum logic [1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_label_t;

  typedef struct packed {
    logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
  } head_data_t;

  typedef union packed {
    head_data_t                head_data;
    logic [FLIT_DATA_SIZE-1:0] bt_pl;
  } flit_data_t;

  typedef struct packed {
    flit_label_t        flit_label;
    logic [VC_SIZE-1:0] vc_id;
    flit_data_t         data;
  } flit_t;
endpackage

// Per-VC credit counter: starts full, saturates on an illegal over-return.
module node_packetizer_credit #(
  parameter int BUFFER_SIZE = 8,
  parameter int CW          = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] count_o
);
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 cnt_q <= CW'(BUFFER_SIZE);
    else if (inc_i && !dec_i) begin
      if (cnt_q != CW'(BUFFER_SIZE)) cnt_q <= cnt_q + 1'b1;
    end
    else if (dec_i && !inc_i) cnt_q <= cnt_q - 1'b1;
  end

  // A credit returned while already full means the router freed a slot we
  // never used.
  credit_overflow_a: assert property (@(posedge clk) disable iff (!rst)
    !(inc_i && !dec_i && cnt_q == CW'(BUFFER_SIZE)));

  assign count_o = cnt_q;
endmodule

module node_packetizer #(
  parameter  int BUFFER_SIZE    = 8,
  parameter  int MAX_BODY_FLITS = 15,
  localparam int LEN_W          = $clog2(MAX_BODY_FLITS + 1)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     pkt_valid_i,
  output logic                                     pkt_ready_o,
  input  logic [noc_params::DEST_ADDR_SIZE_X-1:0]  pkt_x_dest_i,
  input  logic [noc_params::DEST_ADDR_SIZE_Y-1:0]  pkt_y_dest_i,
  input  logic [noc_params::HEAD_PAYLOAD_SIZE-1:0] pkt_head_pl_i,
  input  logic [LEN_W-1:0]                         pkt_body_len_i,
  input  logic                                     body_valid_i,
  output logic                                     body_ready_o,
  input  logic [noc_params::FLIT_DATA_SIZE-1:0]    body_data_i,
  input  logic [noc_params::VC_NUM-1:0]            vc_allocatable_i,
  input  logic [noc_params::VC_NUM-1:0]            credit_i,
  output noc_params::flit_t                        flit_o,
  output logic                                     valid_flit_o
`ifdef PACKETIZER_STATS_EN
  ,
  output logic [15:0]                              pkt_count_o,
  output logic [15:0]                              flit_count_o
`endif
);
  localparam int VC_NUM = noc_params::VC_NUM;
  localparam int VW     = noc_params::VC_SIZE;
  localparam int CW     = $clog2(BUFFER_SIZE + 1);

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY} state_t;

  state_t                 state_q, state_d;
  noc_params::head_data_t hd_q, hd_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       rem_q, rem_d;
  logic [VW-1:0]          cur_vc_q, cur_vc_d;
  logic [VW-1:0]          rr_q, rr_d;
  noc_params::flit_t      flit_q, flit_d;
  logic                   vld_q, vld_d;

  logic [VC_NUM-1:0][CW-1:0] credit;
  logic [VC_NUM-1:0]         eligible, dec;
  logic [VW-1:0]             pick_vc;
  logic                      pick_found;
  logic                      cur_has_credit;
  logic                      launch, launch_last;

  // Per-VC credit counters
  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    assign eligible[v] = vc_allocatable_i[v] && (credit[v] != '0);
    assign dec[v]      = launch && (cur_vc_q == VW'(v));
    node_packetizer_credit #(.BUFFER_SIZE(BUFFER_SIZE), .CW(CW)) u_cred (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (credit_i[v]),
      .dec_i   (dec[v]),
      .count_o (credit[v])
    );
  end

  assign cur_has_credit = (credit[cur_vc_q] != '0);

  // Round robin: first eligible VC strictly after the last one granted.
  always_comb begin
    pick_vc    = rr_q;
    pick_found = 1'b0;
    for (int i = 1; i <= VC_NUM; i++) begin
      if (!pick_found && eligible[(int'(rr_q) + i) % VC_NUM]) begin
        pick_found = 1'b1;
        pick_vc    = VW'((int'(rr_q) + i) % VC_NUM);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    hd_d         = hd_q;
    len_d        = len_q;
    rem_d        = rem_q;
    cur_vc_d     = cur_vc_q;
    rr_d         = rr_q;
    flit_d       = flit_q;
    vld_d        = 1'b0;
    launch       = 1'b0;
    launch_last  = 1'b0;
    pkt_ready_o  = 1'b0;
    body_ready_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Held low during reset so nothing is accepted before counters settle.
        pkt_ready_o = rst && (|eligible);
        if (pkt_valid_i && pkt_ready_o) begin
          hd_d     = '{x_dest: pkt_x_dest_i, y_dest: pkt_y_dest_i, head_pl: pkt_head_pl_i};
          len_d    = pkt_body_len_i;
          cur_vc_d = pick_vc;
          rr_d     = pick_vc;
          state_d  = S_HEAD;
        end
      end
      S_HEAD: begin
        if (cur_has_credit) begin
          launch                = 1'b1;
          launch_last           = (len_q == '0);
          vld_d                 = 1'b1;
          flit_d.flit_label     = (len_q == '0) ? noc_params::HEADTAIL : noc_params::HEAD;
          flit_d.vc_id          = cur_vc_q;
          flit_d.data.head_data = hd_q;
          rem_d                 = len_q;
          state_d               = (len_q == '0) ? S_IDLE : S_BODY;
        end
      end
      S_BODY: begin
        body_ready_o = cur_has_credit;
        if (body_valid_i && cur_has_credit) begin
          launch            = 1'b1;
          launch_last       = (rem_q == LEN_W'(1));
          vld_d             = 1'b1;
          flit_d.flit_label = (rem_q == LEN_W'(1)) ? noc_params::TAIL : noc_params::BODY;
          flit_d.vc_id      = cur_vc_q;
          flit_d.data.bt_pl = body_data_i;
          rem_d             = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      hd_q     <= '0;
      len_q    <= '0;
      rem_q    <= '0;
      cur_vc_q <= '0;
      rr_q     <= VW'(VC_NUM - 1);
      flit_q   <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hd_q     <= hd_d;
      len_q    <= len_d;
      rem_q    <= rem_d;
      cur_vc_q <= cur_vc_d;
      rr_q     <= rr_d;
      flit_q   <= flit_d;
      vld_q    <= vld_d;
    end
  end

  assign flit_o       = flit_q;
  assign valid_flit_o = vld_q;

  // Only reachable when MAX_BODY_FLITS is not of the form 2^k-1.
  body_len_range_a: assert property (@(posedge clk) disable iff (!rst)
    (pkt_valid_i && pkt_ready_o) |-> (pkt_body_len_i <= LEN_W'(MAX_BODY_FLITS)));

`ifdef PACKETIZER_STATS_EN
  logic [15:0] pkt_cnt_q, flit_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt_q  <= '0;
      flit_cnt_q <= '0;
    end else begin
      if (launch)      flit_cnt_q <= flit_cnt_q + 16'd1;
      if (launch_last) pkt_cnt_q  <= pkt_cnt_q + 16'd1;
    end
  end

  assign pkt_count_o  = pkt_cnt_q;
  assign flit_count_o = flit_cnt_q;
`endif
endmodule

// File: tb/tb_node_packetizer.sv
// Directed bench for node_packetizer (default parameters: 2 VCs, 8 credits,
// 25-bit flit = {label[1:0], vc[0], data[21:0]}).
module tb_node_packetizer;
  logic        clk, rst;
  logic        pkt_valid, pkt_ready;
  logic [2:0]  pkt_x, pkt_y;
  logic [15:0] pkt_pl;
  logic [3:0]  pkt_len;
  logic        body_valid, body_ready;
  logic [21:0] body_data;
  logic [1:0]  vc_alloc, credit_in;
  noc_params::flit_t flit;
  logic        valid_flit;
`ifdef PACKETIZER_STATS_EN
  logic [15:0] pkt_count, flit_count;
`endif

  node_packetizer dut (
    .clk              (clk),
    .rst              (rst),
    .pkt_valid_i      (pkt_valid),
    .pkt_ready_o      (pkt_ready),
    .pkt_x_dest_i     (pkt_x),
    .pkt_y_dest_i     (pkt_y),
    .pkt_head_pl_i    (pkt_pl),
    .pkt_body_len_i   (pkt_len),
    .body_valid_i     (body_valid),
    .body_ready_o     (body_ready),
    .body_data_i      (body_data),
    .vc_allocatable_i (vc_alloc),
    .credit_i         (credit_in),
    .flit_o           (flit),
    .valid_flit_o     (valid_flit)
`ifdef PACKETIZER_STATS_EN
    ,
    .pkt_count_o      (pkt_count),
    .flit_count_o     (flit_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] L_HEAD = 2'b00, L_BODY = 2'b01, L_TAIL = 2'b10, L_HT = 2'b11;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [24:0] mkhead(logic [1:0] lbl, logic vc, logic [2:0] x,
                                         logic [2:0] y, logic [15:0] pl);
    return {lbl, vc, x, y, pl};
  endfunction

  function automatic logic [24:0] mkbody(logic [1:0] lbl, logic vc, logic [21:0] d);
    return {lbl, vc, d};
  endfunction

  // Inputs are driven, and outputs sampled, 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    pkt_valid  = 1'b0;
    body_valid = 1'b0;
    credit_in  = 2'b00;
    #2;
    rst = 1'b1;
    step();
  endtask

  task automatic send_desc(input logic [2:0] x, input logic [2:0] y,
                           input logic [15:0] pl, input logic [3:0] len);
    pkt_x     = x;
    pkt_y     = y;
    pkt_pl    = pl;
    pkt_len   = len;
    pkt_valid = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  alloc;
    logic [2:0]  x, y;
    logic [15:0] pl;
    logic        exp_vc;
  } rr_vec_t;

  rr_vec_t tbl[6];
  int      nflits;

  initial begin
    // HEADTAIL packets, round-robin history carried across entries
    // (pointer starts at VC 1, so the first grant is VC 0).
    tbl[0] = '{alloc: 2'b11, x: 3'd1, y: 3'd2, pl: 16'h1111, exp_vc: 1'b0};
    tbl[1] = '{alloc: 2'b11, x: 3'd2, y: 3'd3, pl: 16'h2222, exp_vc: 1'b1};
    tbl[2] = '{alloc: 2'b01, x: 3'd3, y: 3'd4, pl: 16'h3333, exp_vc: 1'b0};
    tbl[3] = '{alloc: 2'b01, x: 3'd4, y: 3'd5, pl: 16'h4444, exp_vc: 1'b0};
    tbl[4] = '{alloc: 2'b10, x: 3'd5, y: 3'd6, pl: 16'h5555, exp_vc: 1'b1};
    tbl[5] = '{alloc: 2'b11, x: 3'd6, y: 3'd7, pl: 16'h6666, exp_vc: 1'b0};

    rst = 1'b0; pkt_valid = 1'b0; body_valid = 1'b0; credit_in = 2'b00;
    pkt_x = '0; pkt_y = '0; pkt_pl = '0; pkt_len = '0; body_data = '0;
    vc_alloc = 2'b11;
    step();
    step();

    // ---- reset state
    chk("rst_valid",      32'(valid_flit),        32'd0);
    chk("rst_flit",       32'(flit),              32'd0);
    chk("rst_pkt_ready",  32'(pkt_ready),         32'd0);
    chk("rst_body_ready", 32'(body_ready),        32'd0);
    chk("rst_credit0",    32'(dut.credit[0]),     32'd8);
    chk("rst_credit1",    32'(dut.credit[1]),     32'd8);
    chk("rst_state",      32'(dut.state_q),       32'd0);
    #2; rst = 1'b1;
    step();

    // ---- HEADTAIL
    send_desc(3'd3, 3'd1, 16'hBEEF, 4'd0);
    #1;
    chk("ht_pkt_ready", 32'(pkt_ready), 32'd1);
    step();
    pkt_valid = 1'b0;
    chk("ht_no_early_flit", 32'(valid_flit), 32'd0);
    step();
    chk("ht_valid",   32'(valid_flit),    32'd1);
    chk("ht_flit",    32'(flit),          32'(mkhead(L_HT, 1'b0, 3'd3, 3'd1, 16'hBEEF)));
    chk("ht_credit0", 32'(dut.credit[0]), 32'd7);
    chk("ht_state",   32'(dut.state_q),   32'd0);
    step();
    chk("ht_valid_drop", 32'(valid_flit), 32'd0);
    chk("ht_flit_hold",  32'(flit),       32'(mkhead(L_HT, 1'b0, 3'd3, 3'd1, 16'hBEEF)));

    // ---- 4-flit packet, bodies back-to-back
    do_reset();
    send_desc(3'd2, 3'd5, 16'h1234, 4'd3);
    step();
    pkt_valid = 1'b0; body_valid = 1'b1; body_data = 22'h1;
    step();
    chk("p4_head", 32'(flit), 32'(mkhead(L_HEAD, 1'b0, 3'd2, 3'd5, 16'h1234)));
    chk("p4_head_v", 32'(valid_flit), 32'd1);
    step();
    chk("p4_body1", 32'(flit), 32'(mkbody(L_BODY, 1'b0, 22'h1)));
    chk("p4_body1_v", 32'(valid_flit), 32'd1);
    body_data = 22'h2;
    step();
    chk("p4_body2", 32'(flit), 32'(mkbody(L_BODY, 1'b0, 22'h2)));
    body_data = 22'h3;
    step();
    chk("p4_tail", 32'(flit), 32'(mkbody(L_TAIL, 1'b0, 22'h3)));
    chk("p4_tail_v", 32'(valid_flit), 32'd1);
    body_valid = 1'b0;
    chk("p4_credit0", 32'(dut.credit[0]), 32'd4);
    chk("p4_state",   32'(dut.state_q),   32'd0);
    step();
    chk("p4_after_v", 32'(valid_flit), 32'd0);

    // ---- credit stall: 8 credits, len=15, no returns
    do_reset();
    send_desc(3'd1, 3'd1, 16'hAAAA, 4'd15);
    step();
    pkt_valid = 1'b0; body_valid = 1'b1; body_data = 22'h155;
    nflits = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (valid_flit) nflits++;
    end
    chk("stall_nflits",     32'(nflits),         32'd8);
    chk("stall_body_ready", 32'(body_ready),     32'd0);
    chk("stall_credit0",    32'(dut.credit[0]),  32'd0);
    credit_in = 2'b01;
    step();
    credit_in = 2'b00;
    nflits = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (valid_flit) nflits++;
    end
    chk("stall_one_more",    32'(nflits),     32'd1);
    chk("stall_ready_again", 32'(body_ready), 32'd0);
    body_valid = 1'b0;

    // ---- round robin table
    do_reset();
    for (int i = 0; i < 6; i++) begin
      vc_alloc = tbl[i].alloc;
      send_desc(tbl[i].x, tbl[i].y, tbl[i].pl, 4'd0);
      #1;
      chk($sformatf("rr%0d_pkt_ready", i), 32'(pkt_ready), 32'd1);
      step();
      pkt_valid = 1'b0;
      step();
      chk($sformatf("rr%0d_valid", i), 32'(valid_flit), 32'd1);
      chk($sformatf("rr%0d_flit", i), 32'(flit),
          32'(mkhead(L_HT, tbl[i].exp_vc, tbl[i].x, tbl[i].y, tbl[i].pl)));
    end
    chk("rr_credit0", 32'(dut.credit[0]), 32'd4);
    chk("rr_credit1", 32'(dut.credit[1]), 32'd6);

    // ---- simultaneous credit return and launch
    do_reset();
    vc_alloc = 2'b01;
    send_desc(3'd0, 3'd0, 16'h0001, 4'd0);
    step();
    pkt_valid = 1'b0;
    step();
    chk("sim_first_credit", 32'(dut.credit[0]), 32'd7);
    send_desc(3'd0, 3'd0, 16'h0002, 4'd0);
    step();
    pkt_valid = 1'b0; credit_in = 2'b01;
    step();
    credit_in = 2'b00;
    chk("sim_launch_v", 32'(valid_flit),    32'd1);
    chk("sim_credit0",  32'(dut.credit[0]), 32'd7);
    vc_alloc = 2'b00;
    pkt_valid = 1'b1;
    #1;
    chk("noelig_pkt_ready", 32'(pkt_ready), 32'd0);
    pkt_valid = 1'b0;
    vc_alloc = 2'b11;

    // ---- reset in the middle of a packet
    do_reset();
    send_desc(3'd4, 3'd2, 16'hCAFE, 4'd5);
    step();
    pkt_valid = 1'b0;
    step();
    chk("mid_head", 32'(flit), 32'(mkhead(L_HEAD, 1'b0, 3'd4, 3'd2, 16'hCAFE)));
    body_valid = 1'b1; body_data = 22'h3F;
    rst = 1'b0;
    #1;
    chk("mid_valid",   32'(valid_flit),    32'd0);
    chk("mid_credit0", 32'(dut.credit[0]), 32'd8);
    chk("mid_state",   32'(dut.state_q),   32'd0);
    #2; rst = 1'b1;
    nflits = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (valid_flit || body_ready) nflits++;
    end
    chk("mid_no_more_flits", 32'(nflits), 32'd0);
    body_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
